// File: rtl/key_conditioner.sv
// Two-key push-button conditioner: synchronise, debounce, and emit level plus
// press/release/short/long/combo event pulses in the Div_CLK domain.
module key_conditioner #(
    parameter int unsigned DEBOUNCE_TICKS = 200,
    parameter int unsigned LONG_TICKS     = 20000,
    parameter logic        PRESS_LEVEL    = 1'b0
) (
    input  logic       Div_CLK,
    input  logic       Sys_RST,
    input  logic [1:0] Key,
    output logic [1:0] Key_Level,
    output logic [1:0] Key_Press,
    output logic [1:0] Key_Release,
    output logic [1:0] Key_Short,
    output logic [1:0] Key_Long,
    output logic       Key_Both
);

    localparam int unsigned DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam int unsigned HW = $clog2(LONG_TICKS + 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t        state_q [2];
    state_t        state_d [2];
    logic [DW-1:0] deb_q   [2];
    logic [DW-1:0] deb_d   [2];
    logic [HW-1:0] hold_q  [2];
    logic [HW-1:0] hold_d  [2];

    logic [1:0] sync1_q, sync2_q, sample;
    logic [1:0] flag_q, flag_d;
    logic [1:0] level_q, level_d;
    logic [1:0] press_q, press_d;
    logic [1:0] release_q, release_d;
    logic [1:0] short_q, short_d;
    logic [1:0] long_q, long_d;
    logic       both_q, both_d;

    assign sample = PRESS_LEVEL ? sync2_q : ~sync2_q;

    always_ff @(posedge Div_CLK or posedge Sys_RST) begin
        if (Sys_RST) begin
            sync1_q <= {2{~PRESS_LEVEL}};
            sync2_q <= {2{~PRESS_LEVEL}};
        end else begin
            sync1_q <= Key;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        press_d   = '0;
        release_d = '0;
        long_d    = '0;
        level_d   = '0;
        for (int unsigned k = 0; k < 2; k++) begin
            state_d[k] = state_q[k];
            deb_d[k]   = deb_q[k];
            hold_d[k]  = hold_q[k];
            // Hold time keeps accruing through a release bounce; it saturates so Long fires once.
            if (state_q[k] == PRESSED || state_q[k] == RELEASE_WAIT) begin
                if (hold_q[k] != HW'(LONG_TICKS))
                    hold_d[k] = hold_q[k] + 1'b1;
                long_d[k] = (hold_q[k] == HW'(LONG_TICKS - 1));
            end
            case (state_q[k])
                IDLE: begin
                    if (sample[k]) begin
                        state_d[k] = PRESS_WAIT;
                        deb_d[k]   = DW'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (!sample[k]) begin
                        state_d[k] = IDLE;
                    end else if (deb_q[k] >= DW'(DEBOUNCE_TICKS - 1)) begin
                        state_d[k] = PRESSED;
                        press_d[k] = 1'b1;
                        hold_d[k]  = '0;
                    end else begin
                        deb_d[k] = deb_q[k] + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!sample[k]) begin
                        state_d[k] = RELEASE_WAIT;
                        deb_d[k]   = DW'(1);
                    end
                end
                RELEASE_WAIT: begin
                    if (sample[k]) begin
                        state_d[k] = PRESSED;
                    end else if (deb_q[k] >= DW'(DEBOUNCE_TICKS - 1)) begin
                        state_d[k]   = IDLE;
                        release_d[k] = 1'b1;
                    end else begin
                        deb_d[k] = deb_q[k] + 1'b1;
                    end
                end
                default: state_d[k] = IDLE;
            endcase
            level_d[k] = (state_d[k] == PRESSED) || (state_d[k] == RELEASE_WAIT);
        end
    end

    always_comb begin
        both_d = (press_d[0] & (level_q[1] | press_d[1])) | (press_d[1] & level_q[0]);
        for (int unsigned k = 0; k < 2; k++) begin
            flag_d[k] = flag_q[k];
            if (press_d[k])
                flag_d[k] = 1'b0;
            if (long_d[k] || both_d)
                flag_d[k] = 1'b1;
            // A Long or combo landing on the release cycle still counts against Short.
            short_d[k] = release_d[k] & ~flag_q[k] & ~long_d[k] & ~both_d;
        end
    end

    always_ff @(posedge Div_CLK or posedge Sys_RST) begin
        if (Sys_RST) begin
            for (int unsigned k = 0; k < 2; k++) begin
                state_q[k] <= IDLE;
                deb_q[k]   <= '0;
                hold_q[k]  <= '0;
            end
            flag_q    <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            short_q   <= '0;
            long_q    <= '0;
            both_q    <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < 2; k++) begin
                state_q[k] <= state_d[k];
                deb_q[k]   <= deb_d[k];
                hold_q[k]  <= hold_d[k];
            end
            flag_q    <= flag_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            short_q   <= short_d;
            long_q    <= long_d;
            both_q    <= both_d;
        end
    end

    assign Key_Level   = level_q;
    assign Key_Press   = press_q;
    assign Key_Release = release_q;
    assign Key_Short   = short_q;
    assign Key_Long    = long_q;
    assign Key_Both    = both_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed scenarios plus random key activity, all
// checked every cycle against a window-based behavioural model.
module tb_key_conditioner;

    localparam int D  = 4;
    localparam int L  = 10;
    localparam logic PL = 1'b0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] key = 2'b11;
    logic [1:0] lvl_o, prs_o, rel_o, sht_o, lng_o;
    logic       both_o;

    int n_checks = 0;
    int n_fail   = 0;

    key_conditioner #(.DEBOUNCE_TICKS(D), .LONG_TICKS(L), .PRESS_LEVEL(PL)) dut (
        .Div_CLK    (clk),
        .Sys_RST    (rst),
        .Key        (key),
        .Key_Level  (lvl_o),
        .Key_Press  (prs_o),
        .Key_Release(rel_o),
        .Key_Short  (sht_o),
        .Key_Long   (lng_o),
        .Key_Both   (both_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a key's debounced level flips once the last D synchronised samples
    // all disagree with it; events are derived from edge counts since the press.
    int   n;
    bit   d1 [2], d2 [2];
    bit   hist [2][D];
    bit   m_lvl [2], prod [2];
    int   pedge [2];
    logic [1:0] e_lvl, e_prs, e_rel, e_sht, e_lng;
    logic       e_both;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n = 0;
            for (int k = 0; k < 2; k++) begin
                d1[k] = 0; d2[k] = 0; m_lvl[k] = 0; prod[k] = 0; pedge[k] = 0;
                for (int j = 0; j < D; j++) hist[k][j] = 0;
            end
            e_lvl = '0; e_prs = '0; e_rel = '0; e_sht = '0; e_lng = '0; e_both = 1'b0;
        end else begin
            bit all1, all0, bo;
            bit pr [2], rl [2], lg [2];
            n++;
            for (int k = 0; k < 2; k++) begin
                bit s;
                s = d2[k];
                d2[k] = d1[k];
                d1[k] = (key[k] == PL);
                for (int j = D - 1; j > 0; j--) hist[k][j] = hist[k][j-1];
                hist[k][0] = s;
                all1 = 1; all0 = 1;
                for (int j = 0; j < D; j++) begin
                    if (!hist[k][j]) all1 = 0;
                    if (hist[k][j])  all0 = 0;
                end
                pr[k] = !m_lvl[k] && all1;
                rl[k] = m_lvl[k] && all0;
                lg[k] = m_lvl[k] && (n - pedge[k] == L);
            end
            bo = (pr[0] && (m_lvl[1] || pr[1])) || (pr[1] && m_lvl[0]);
            for (int k = 0; k < 2; k++) begin
                e_sht[k] = rl[k] && !prod[k] && !lg[k] && !bo;
                if (pr[k]) begin m_lvl[k] = 1; pedge[k] = n; prod[k] = 0; end
                if (lg[k] || bo) prod[k] = 1;
                if (rl[k]) m_lvl[k] = 0;
                e_prs[k] = pr[k];
                e_rel[k] = rl[k];
                e_lng[k] = lg[k];
                e_lvl[k] = m_lvl[k];
            end
            e_both = bo;
        end
    end

    always @(negedge clk) begin
        chk("level",   lvl_o, e_lvl);
        chk("press",   prs_o, e_prs);
        chk("release", rel_o, e_rel);
        chk("short",   sht_o, e_sht);
        chk("long",    lng_o, e_lng);
        chk("both",    {1'b0, both_o}, {1'b0, e_both});
    end

    task automatic tick(input int c = 1);
        for (int i = 0; i < c; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        int rem [2];

        // 1: quiet idle, then a clean press of key 0
        key = 2'b11;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            chk("idle_quiet", prs_o | rel_o | sht_o | lng_o | lvl_o | {1'b0, both_o}, 2'b00);
            tick();
        end
        key = 2'b10;
        tick(5);
        chk("press0_early", prs_o, 2'b00);
        tick();
        chk("press0_at6", prs_o, 2'b01);
        chk("level0_at6", lvl_o, 2'b01);
        tick();
        chk("press0_one_cycle", prs_o, 2'b00);
        chk("level0_held", lvl_o, 2'b01);
        key = 2'b11;
        tick(6);
        chk("release0_at6", rel_o, 2'b01);
        chk("short0_at6", sht_o, 2'b01);
        tick(4);

        // 2: 3-cycle glitch rejected, 4-cycle glitch accepted
        key = 2'b10;
        tick(3);
        key = 2'b11;
        for (int i = 0; i < 12; i++) begin
            chk("glitch3_press", prs_o, 2'b00);
            chk("glitch3_level", lvl_o, 2'b00);
            tick();
        end
        key = 2'b10;
        tick(4);
        key = 2'b11;
        tick(2);
        chk("glitch4_press", prs_o, 2'b01);
        tick(10);

        // 3: short press on key 1
        key = 2'b01;
        tick(8);
        key = 2'b11;
        tick(6);
        chk("short1_release", rel_o, 2'b10);
        chk("short1_short", sht_o, 2'b10);
        tick(4);

        // 4: long press on key 0
        key = 2'b10;
        tick(16);
        chk("long0_at16", lng_o, 2'b01);
        tick(14);
        key = 2'b11;
        tick(6);
        chk("long0_release", rel_o, 2'b01);
        chk("long0_no_short", sht_o, 2'b00);
        tick(4);

        // 5: simultaneous combo, then staggered combo
        key = 2'b00;
        tick(6);
        chk("combo_both", {1'b0, both_o}, 2'b01);
        chk("combo_press", prs_o, 2'b11);
        tick(5);
        key = 2'b11;
        tick(6);
        chk("combo_release", rel_o, 2'b11);
        chk("combo_no_short", sht_o, 2'b00);
        tick(4);
        key = 2'b10;
        tick(3);
        key = 2'b00;
        tick(6);
        chk("stagger_both", {1'b0, both_o}, 2'b01);
        chk("stagger_press", prs_o, 2'b10);
        tick(3);
        key = 2'b11;
        tick(10);

        // 6: reset while key 0 is held
        key = 2'b10;
        tick(8);
        rst = 1'b1;
        #1;
        chk("rst_level_clear", lvl_o, 2'b00);
        tick();
        rst = 1'b0;
        tick(5);
        chk("rst_press_early", prs_o, 2'b00);
        tick();
        chk("rst_repress", prs_o, 2'b01);
        for (int i = 0; i < 8; i++) begin
            chk("rst_no_release", rel_o, 2'b00);
            tick();
        end
        key = 2'b11;
        tick(10);

        // Random activity: runs of mixed short bounces and long holds per key
        rem[0] = 1; rem[1] = 1;
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < 2; k++) begin
                rem[k]--;
                if (rem[k] == 0) begin
                    key[k] = ~key[k];
                    rem[k] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5))
                                                          : int'($urandom_range(6, 25));
                end
            end
            if (c == 2000) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            tick();
        end
        key = 2'b11;
        tick(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
